mem_port_arbiter: RTL and testbench

- Sequences the single shared memory port between three requesters:
  - 0 = instruction fetch (IF state)
  - 1 = data access (LDUR/STUR execute)
  - 2 = I/O/DMA
- Round-robin arbitration, a programmable wait-state counter and a one-cycle ack handshake.
- Sits between the control unit/datapath and the RAM. The control unit holds its state while awaiting ack.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sequencer for the single shared memory port
// Ports:
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_req, i_write         : per-requester request and direction (0 = fetch, 1 = data, 2 = I/O-DMA)
//   i_addr, i_wdata        : packed per-requester address / store data, requester i at [i*W +: W]
//   o_ack, o_rdata         : one-hot single-cycle completion strobe, load data held until next ack
//   o_grant, o_busy        : owner of the port during ACCESS/ACK, port-in-use flag
//   o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write, i_mem_rdata : RAM side

module mem_port_arbiter #(
    parameter int AW   = 64,
    parameter int DW   = 64,
    parameter int WAIT = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [2:0]        i_req,
    input  logic [2:0]        i_write,
    input  logic [3*AW-1:0]   i_addr,
    input  logic [3*DW-1:0]   i_wdata,
    output logic [2:0]        o_ack,
    output logic [DW-1:0]     o_rdata,
    output logic [2:0]        o_grant,
    output logic              o_busy,
    output logic [AW-1:0]     o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DW-1:0]     i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t          r_state;
    state_t          w_next_state;
    logic [3:0]      r_count;
    logic [1:0]      r_winner;
    logic [1:0]      r_last;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_write;
    logic [DW-1:0]   r_rdata;

    logic [1:0]      w_p0;
    logic [1:0]      w_p1;
    logic [1:0]      w_p2;
    logic [1:0]      w_pick;
    logic            w_any;
    logic [2:0]      w_winner_oh;

    // Search order starts just after the last served requester, so the
    // requester served most recently always has the lowest priority.
    always_comb begin
        case (r_last)
            2'd0: begin
                w_p0 = 2'd1;
                w_p1 = 2'd2;
                w_p2 = 2'd0;
            end
            2'd1: begin
                w_p0 = 2'd2;
                w_p1 = 2'd0;
                w_p2 = 2'd1;
            end
            default: begin
                w_p0 = 2'd0;
                w_p1 = 2'd1;
                w_p2 = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_pick = w_p2;
        if (i_req[w_p1]) begin
            w_pick = w_p1;
        end
        if (i_req[w_p0]) begin
            w_pick = w_p0;
        end
    end

    assign w_any       = |i_req;
    assign w_winner_oh = 3'b001 << r_winner;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count  <= 4'd0;
            r_winner <= 2'd0;
            r_last   <= 2'd2;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The transaction is captured here; later input changes
                    // from the requester have no effect on this access.
                    if (w_any) begin
                        r_winner <= w_pick;
                        r_addr   <= i_addr[w_pick*AW +: AW];
                        r_wdata  <= i_wdata[w_pick*DW +: DW];
                        r_write  <= i_write[w_pick];
                        r_count  <= WAIT_CNT;
                    end
                end
                S_ACCESS: begin
                    if (r_count == 4'd0) begin
                        if (!r_write) begin
                            r_rdata <= i_mem_rdata;
                        end
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                S_ACK: begin
                    r_last <= r_winner;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ack        = 3'b000;
        o_grant      = 3'b000;
        o_busy       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                o_grant     = w_winner_oh;
                o_busy      = 1'b1;
                o_mem_read  = ~r_write;
                o_mem_write = r_write;
                if (r_count == 4'd0) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK: begin
                o_ack        = w_winner_oh;
                o_grant      = w_winner_oh;
                o_busy       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (WAIT=2 and WAIT=0 instances)

module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    int                cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance, WAIT = 2
    logic [2:0]        req, wr;
    logic [3*AW-1:0]   addr;
    logic [3*DW-1:0]   wdata;
    logic [2:0]        ack, grant;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              busy, mem_read, mem_write;

    // second instance, WAIT = 0
    logic [2:0]        z_req, z_wr;
    logic [3*AW-1:0]   z_addr;
    logic [3*DW-1:0]   z_wdata;
    logic [2:0]        z_ack, z_grant;
    logic [DW-1:0]     z_rdata, z_mem_wdata, z_mem_rdata;
    logic [AW-1:0]     z_mem_addr;
    logic              z_busy, z_mem_read, z_mem_write;

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(W)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_req(req), .i_write(wr), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack), .o_rdata(rdata), .o_grant(grant), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .i_mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_req(z_req), .i_write(z_wr), .i_addr(z_addr), .i_wdata(z_wdata),
        .o_ack(z_ack), .o_rdata(z_rdata), .o_grant(z_grant), .o_busy(z_busy),
        .o_mem_addr(z_mem_addr), .o_mem_wdata(z_mem_wdata), .o_mem_read(z_mem_read),
        .o_mem_write(z_mem_write), .i_mem_rdata(z_mem_rdata)
    );

    // RAM model: data is only valid in the last read cycle of an access
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h40) ? 64'hDEAD : (a ^ 64'hFACE_0000);
    endfunction

    int mcnt = 0;
    int zcnt = 0;
    always @(posedge clk) mcnt <= mem_read ? mcnt + 1 : 0;
    always @(posedge clk) zcnt <= z_mem_read ? zcnt + 1 : 0;
    assign mem_rdata   = (mem_read && mcnt == W) ? mem_fn(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    assign z_mem_rdata = (z_mem_read && zcnt == 0) ? mem_fn(z_mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        int          c;
        logic        rd;
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic [2:0]  g;
    } mem_exp_t;

    typedef struct {
        int          c;
        logic [2:0]  ack;
        logic [63:0] rdata;
    } ack_exp_t;

    mem_exp_t q_mem[$];
    ack_exp_t q_ack[$];
    ack_exp_t q_zack[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // expectations for one access sampled in IDLE at cycle t
    task automatic exp_access(input int t, input int wt, input logic [1:0] id, input logic w,
                              input logic [63:0] a, input logic [63:0] d,
                              input logic [63:0] rd_exp, input bit on_z);
        mem_exp_t m;
        ack_exp_t k;
        if (!on_z) begin
            for (int i = 1; i <= wt + 1; i++) begin
                m.c = t + i; m.rd = ~w; m.wr = w; m.a = a; m.d = d; m.g = 3'b001 << id;
                q_mem.push_back(m);
            end
        end
        k.c = t + wt + 2; k.ack = 3'b001 << id; k.rdata = rd_exp;
        if (on_z) q_zack.push_back(k);
        else      q_ack.push_back(k);
    endtask

    always @(negedge clk) begin : mon_mem
        mem_exp_t e;
        if (mem_read || mem_write) begin
            if (q_mem.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mem_unexpected: got rd=%0b wr=%0b required no access (cycle %0d)", mem_read, mem_write, cyc);
            end else begin
                e = q_mem.pop_front();
                check("mem_cycle", 64'(cyc), 64'(e.c));
                check("mem_read", 64'(mem_read), 64'(e.rd));
                check("mem_write", 64'(mem_write), 64'(e.wr));
                check("mem_addr", mem_addr, e.a);
                check("mem_wdata", mem_wdata, e.d);
                check("grant_access", 64'(grant), 64'(e.g));
                check("busy_access", 64'(busy), 64'd1);
            end
        end
    end

    always @(negedge clk) begin : mon_ack
        ack_exp_t e;
        if (ack != 3'b000) begin
            if (q_ack.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL ack_unexpected: got %0b required none (cycle %0d)", ack, cyc);
            end else begin
                e = q_ack.pop_front();
                check("ack_cycle", 64'(cyc), 64'(e.c));
                check("ack_value", 64'(ack), 64'(e.ack));
                check("ack_rdata", rdata, e.rdata);
                check("grant_ack", 64'(grant), 64'(e.ack));
                check("busy_ack", 64'(busy), 64'd1);
            end
        end
    end

    always @(negedge clk) begin : mon_zack
        ack_exp_t e;
        if (z_ack != 3'b000) begin
            if (q_zack.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL w0_ack_unexpected: got %0b required none (cycle %0d)", z_ack, cyc);
            end else begin
                e = q_zack.pop_front();
                check("w0_ack_cycle", 64'(cyc), 64'(e.c));
                check("w0_ack_value", 64'(z_ack), 64'(e.ack));
                check("w0_ack_rdata", z_rdata, e.rdata);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(ack), 64'd0);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_mem_read"}, 64'(mem_read), 64'd0);
        check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
        check({tag, "_mem_addr"}, mem_addr, 64'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        check({tag, "_rdata"}, rdata, 64'd0);
    endtask

    logic [63:0] t4_rd [3];
    int t;

    initial begin : stim
        rst = 1'b1;
        req = '0; wr = '0; addr = '0; wdata = '0;
        z_req = '0; z_wr = '0; z_addr = '0; z_wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // single load from requester 0, memory returns 0xDEAD
        t = cyc;
        req = 3'b001; wr = 3'b000;
        addr[0*AW +: AW] = 64'h40; wdata[0*DW +: DW] = 64'h5555;
        exp_access(t, W, 2'd0, 1'b0, 64'h40, 64'h5555, 64'hDEAD, 1'b0);
        wait_to(t + 4); req = 3'b000;
        wait_to(t + 5);

        // store from requester 1; inputs change and req drops right after the latch
        t = cyc;
        req = 3'b010; wr = 3'b010;
        addr[1*AW +: AW] = 64'h100; wdata[1*DW +: DW] = 64'h1234;
        exp_access(t, W, 2'd1, 1'b1, 64'h100, 64'h1234, 64'hDEAD, 1'b0);
        step();
        req = 3'b000; wr = 3'b000;
        addr[1*AW +: AW] = 64'h999; wdata[1*DW +: DW] = 64'hFFFF;
        wait_to(t + 5);

        // contention after requester 1 was served: 0 wins, then 1
        t = cyc;
        req = 3'b011; wr = 3'b000;
        addr[0*AW +: AW] = 64'h80; addr[1*AW +: AW] = 64'h108;
        exp_access(t,     W, 2'd0, 1'b0, 64'h80,  64'h5555, 64'hFACE_0080, 1'b0);
        exp_access(t + 5, W, 2'd1, 1'b0, 64'h108, 64'hFFFF, 64'hFACE_0108, 1'b0);
        wait_to(t + 9); req = 3'b000;
        wait_to(t + 10);

        // all three held from reset: order 0,1,2,0,1,2 every WAIT+3 cycles
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        t = cyc;
        req = 3'b111; wr = 3'b100;
        addr  = {64'h400, 64'h300, 64'h200};
        wdata = {64'hABCD, 64'hFFFF, 64'h5555};
        t4_rd[0] = 64'hFACE_0200; t4_rd[1] = 64'hFACE_0300; t4_rd[2] = 64'hFACE_0300;
        for (int k = 0; k < 6; k++) begin
            exp_access(t + 5*k, W, 2'(k % 3), (k % 3) == 2, addr[(k%3)*AW +: AW],
                       wdata[(k%3)*DW +: DW], t4_rd[k % 3], 1'b0);
        end
        wait_to(t + 29); req = 3'b000; wr = 3'b000;
        wait_to(t + 30);

        // reset in the second ACCESS cycle aborts the access
        t = cyc;
        req = 3'b100; addr[2*AW +: AW] = 64'h500;
        exp_access(t, 0, 2'd2, 1'b0, 64'h500, 64'hABCD, 64'd0, 1'b0);
        void'(q_ack.pop_back());
        exp_access(t + 1, 0, 2'd2, 1'b0, 64'h500, 64'hABCD, 64'd0, 1'b0);
        void'(q_ack.pop_back());
        wait_to(t + 2); rst = 1'b1; req = 3'b000;
        wait_to(t + 3);
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        wait_to(t + 4);
        t = cyc;
        req = 3'b100;
        exp_access(t, W, 2'd2, 1'b0, 64'h500, 64'hABCD, 64'hFACE_0500, 1'b0);
        wait_to(t + 4); req = 3'b000;
        wait_to(t + 5);

        // WAIT=0 instance, requester 1 back-to-back with req held across ack
        t = cyc;
        z_req = 3'b010; z_wr = 3'b000; z_addr[1*AW +: AW] = 64'h700;
        for (int k = 0; k < 3; k++) begin
            exp_access(t + 3*k, 0, 2'd1, 1'b0, 64'h700, 64'd0, 64'hFACE_0700, 1'b1);
        end
        wait_to(t + 8); z_req = 3'b000;
        wait_to(t + 12);

        check("left_mem_queue", 64'(q_mem.size()), 64'd0);
        check("left_ack_queue", 64'(q_ack.size()), 64'd0);
        check("left_w0_ack_queue", 64'(q_zack.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
